// File: rtl/ept_tlb_if.sv
// Request/response, flush and EPT lookup signals of the GPA->HPA translation cache.
// The slave modport is the cache's view; master is the requester and EPT side.
interface ept_tlb_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [7:0]  req_vmid_i;
  logic [63:0] req_gpa_i;
  logic        resp_valid_o;
  logic        resp_ready_i;
  logic [63:0] resp_hpa_o;
  logic        resp_fault_o;
  logic        resp_hit_o;
  logic        flush_i;
  logic        flush_all_i;
  logic [7:0]  flush_vmid_i;
  logic        ept_valid_o;
  logic [7:0]  ept_vmid_o;
  logic [63:0] ept_gpa_o;
  logic [63:0] ept_hpa_i;
  logic        ept_fault_i;

  modport slave (
    input  req_valid_i, req_vmid_i, req_gpa_i, resp_ready_i,
    input  flush_i, flush_all_i, flush_vmid_i, ept_hpa_i, ept_fault_i,
    output req_ready_o, resp_valid_o, resp_hpa_o, resp_fault_o, resp_hit_o,
    output ept_valid_o, ept_vmid_o, ept_gpa_o
  );

  modport master (
    output req_valid_i, req_vmid_i, req_gpa_i, resp_ready_i,
    output flush_i, flush_all_i, flush_vmid_i, ept_hpa_i, ept_fault_i,
    input  req_ready_o, resp_valid_o, resp_hpa_o, resp_fault_o, resp_hit_o,
    input  ept_valid_o, ept_vmid_o, ept_gpa_o
  );
endinterface

// File: rtl/ept_tlb.sv
// Fully-associative GPA->HPA cache in front of EPT; one request in flight, hit response 2 cycles, miss 3.
// Backpressure: response held stable until resp_ready_i; no request accepted until the response transfers.
module ept_tlb #(
  parameter int ENTRIES    = 4,
  parameter int PAGE_SHIFT = 12
) (
  input  logic      clk,
  input  logic      rst,
  ept_tlb_if.slave  bus
);
  localparam int IW = $clog2(ENTRIES);
  localparam int VW = 64 - PAGE_SHIFT;

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_WALK, S_RESP} state_t;

  state_t              r_state;
  state_t              w_next;
  logic [7:0]          r_vmid;
  logic [63:0]         r_gpa;
  logic [ENTRIES-1:0]  r_vld;
  logic [7:0]          r_tvmid [ENTRIES];
  logic [VW-1:0]       r_vpn   [ENTRIES];
  logic [VW-1:0]       r_ppn   [ENTRIES];
  logic [IW-1:0]       r_ptr;
  logic                r_resp_vld;
  logic [63:0]         r_resp_hpa;
  logic                r_resp_fault;
  logic                r_resp_hit;

  logic                w_hit;
  logic [IW-1:0]       w_hit_idx;
  logic                w_has_inv;
  logic [IW-1:0]       w_inv_idx;
  logic [IW-1:0]       w_victim;
  logic [ENTRIES-1:0]  w_flush_clr;
  logic                w_fill_blocked;
  logic                w_fill;

  // Descending scan so the lowest matching / lowest invalid index wins.
  always_comb begin
    w_hit       = 1'b0;
    w_hit_idx   = '0;
    w_has_inv   = 1'b0;
    w_inv_idx   = '0;
    w_flush_clr = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (r_vld[i] && (r_tvmid[i] == r_vmid) && (r_vpn[i] == r_gpa[63:PAGE_SHIFT])) begin
        w_hit     = 1'b1;
        w_hit_idx = IW'(i);
      end
      if (!r_vld[i]) begin
        w_has_inv = 1'b1;
        w_inv_idx = IW'(i);
      end
      w_flush_clr[i] = bus.flush_i && (bus.flush_all_i || (r_tvmid[i] == bus.flush_vmid_i));
    end
  end

  assign w_victim       = w_has_inv ? w_inv_idx : r_ptr;
  assign w_fill_blocked = bus.flush_i && (bus.flush_all_i || (bus.flush_vmid_i == r_vmid));
  assign w_fill         = (r_state == S_WALK) && !bus.ept_fault_i && !w_fill_blocked;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.req_valid_i) w_next = S_CHECK;
      S_CHECK: w_next = w_hit ? S_RESP : S_WALK;
      S_WALK:  w_next = S_RESP;
      S_RESP:  if (bus.resp_ready_i) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_vmid       <= '0;
      r_gpa        <= '0;
      r_vld        <= '0;
      r_ptr        <= '0;
      r_resp_vld   <= 1'b0;
      r_resp_hpa   <= '0;
      r_resp_fault <= 1'b0;
      r_resp_hit   <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (bus.req_valid_i) begin
            r_vmid <= bus.req_vmid_i;
            r_gpa  <= bus.req_gpa_i;
          end
        end
        S_CHECK: begin
          if (w_hit) begin
            r_resp_vld   <= 1'b1;
            r_resp_hpa   <= {r_ppn[w_hit_idx], r_gpa[PAGE_SHIFT-1:0]};
            r_resp_fault <= 1'b0;
            r_resp_hit   <= 1'b1;
          end
        end
        S_WALK: begin
          r_resp_vld   <= 1'b1;
          r_resp_hpa   <= bus.ept_fault_i ? 64'h0 : bus.ept_hpa_i;
          r_resp_fault <= bus.ept_fault_i;
          r_resp_hit   <= 1'b0;
        end
        S_RESP: begin
          if (bus.resp_ready_i) r_resp_vld <= 1'b0;
        end
        default: ;
      endcase
      // Flush clears first; a surviving fill then claims its victim slot.
      r_vld <= r_vld & ~w_flush_clr;
      if (w_fill) begin
        r_vld[w_victim]   <= 1'b1;
        r_tvmid[w_victim] <= r_vmid;
        r_vpn[w_victim]   <= r_gpa[63:PAGE_SHIFT];
        r_ppn[w_victim]   <= bus.ept_hpa_i[63:PAGE_SHIFT];
        if (!w_has_inv) r_ptr <= r_ptr + 1'b1;
      end
    end
  end

  assign bus.req_ready_o  = (r_state == S_IDLE) && !rst;
  assign bus.resp_valid_o = r_resp_vld;
  assign bus.resp_hpa_o   = r_resp_hpa;
  assign bus.resp_fault_o = r_resp_fault;
  assign bus.resp_hit_o   = r_resp_hit;
  assign bus.ept_valid_o  = (r_state == S_WALK);
  assign bus.ept_vmid_o   = (r_state == S_WALK) ? r_vmid : 8'h0;
  assign bus.ept_gpa_o    = (r_state == S_WALK) ? r_gpa : 64'h0;
endmodule

// File: tb/tb_ept_tlb.sv
// Directed bench for ept_tlb: table of request vectors plus hand sequences for flush, backpressure, reset.
// The bench also plays the EPT: hpa = gpa + per-vmid key, fault on demand.
module tb_ept_tlb;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tb_fault = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  ept_tlb_if u_if ();

  ept_tlb #(.ENTRIES(4), .PAGE_SHIFT(12)) dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if.slave)
  );

  function automatic logic [63:0] ept_key(input logic [7:0] v);
    return (v == 8'd3) ? 64'h1_0000_0000 : {16'h0, v, 40'h0};
  endfunction

  assign u_if.ept_hpa_i   = u_if.ept_valid_o ? (u_if.ept_gpa_o + ept_key(u_if.ept_vmid_o)) : 64'h0;
  assign u_if.ept_fault_i = u_if.ept_valid_o & tb_fault;

  typedef struct {
    logic        flush_all;
    logic [7:0]  vmid;
    logic [63:0] gpa;
    logic        fault;
    logic [63:0] hpa;
    logic        hit;
    logic        flt;
    int          lat;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic flush_pulse(input logic all, input logic [7:0] v);
    u_if.flush_i      = 1'b1;
    u_if.flush_all_i  = all;
    u_if.flush_vmid_i = v;
    step();
    u_if.flush_i      = 1'b0;
    u_if.flush_all_i  = 1'b0;
  endtask

  task automatic do_req(input logic [7:0] v, input logic [63:0] g, input logic f,
                        input logic [63:0] ehpa, input logic ehit, input logic eflt,
                        input int elat, input logic wflush, input string nm);
    int cyc;
    int ept_cyc;
    int ept_n;
    tb_fault          = f;
    u_if.resp_ready_i = 1'b1;
    u_if.req_vmid_i   = v;
    u_if.req_gpa_i    = g;
    u_if.req_valid_i  = 1'b1;
    chk({nm, ".req_ready"}, 64'(u_if.req_ready_o), 64'd1);
    step();
    u_if.req_valid_i = 1'b0;
    chk({nm, ".ept_gpa_idle"}, u_if.ept_gpa_o, 64'h0);
    cyc = 1; ept_cyc = 0; ept_n = 0;
    while (!u_if.resp_valid_o && cyc < 20) begin
      if (u_if.ept_valid_o) begin
        ept_n++;
        if (ept_cyc == 0) begin
          ept_cyc = cyc;
          chk({nm, ".ept_gpa"}, u_if.ept_gpa_o, g);
          chk({nm, ".ept_vmid"}, 64'(u_if.ept_vmid_o), 64'(v));
        end
        if (wflush) begin
          u_if.flush_i      = 1'b1;
          u_if.flush_all_i  = 1'b0;
          u_if.flush_vmid_i = v;
        end
      end
      step();
      u_if.flush_i = 1'b0;
      cyc++;
    end
    chk({nm, ".lat"}, 64'(cyc), 64'(elat));
    chk({nm, ".ept_cycle"}, 64'(ept_cyc), ehit ? 64'd0 : 64'd2);
    chk({nm, ".ept_count"}, 64'(ept_n), ehit ? 64'd0 : 64'd1);
    chk({nm, ".hpa"}, u_if.resp_hpa_o, ehpa);
    chk({nm, ".hit"}, 64'(u_if.resp_hit_o), 64'(ehit));
    chk({nm, ".fault"}, 64'(u_if.resp_fault_o), 64'(eflt));
    step();
    chk({nm, ".resp_drop"}, 64'(u_if.resp_valid_o), 64'd0);
    tb_fault = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    u_if.req_valid_i  = 1'b0;
    u_if.req_vmid_i   = 8'h0;
    u_if.req_gpa_i    = 64'h0;
    u_if.resp_ready_i = 1'b1;
    u_if.flush_i      = 1'b0;
    u_if.flush_all_i  = 1'b0;
    u_if.flush_vmid_i = 8'h0;

    vecs[0]  = '{1'b0, 8'd3, 64'h1234_5678, 1'b0, 64'h1_1234_5678,    1'b0, 1'b0, 3};
    vecs[1]  = '{1'b0, 8'd3, 64'h1234_5ABC, 1'b0, 64'h1_1234_5ABC,    1'b1, 1'b0, 2};
    vecs[2]  = '{1'b0, 8'd9, 64'h8000,      1'b1, 64'h0,              1'b0, 1'b1, 3};
    vecs[3]  = '{1'b0, 8'd9, 64'h8000,      1'b1, 64'h0,              1'b0, 1'b1, 3};
    vecs[4]  = '{1'b1, 8'd1, 64'h1000,      1'b0, 64'h100_0000_1000,  1'b0, 1'b0, 3};
    vecs[5]  = '{1'b0, 8'd1, 64'h2000,      1'b0, 64'h100_0000_2000,  1'b0, 1'b0, 3};
    vecs[6]  = '{1'b0, 8'd1, 64'h3000,      1'b0, 64'h100_0000_3000,  1'b0, 1'b0, 3};
    vecs[7]  = '{1'b0, 8'd1, 64'h4000,      1'b0, 64'h100_0000_4000,  1'b0, 1'b0, 3};
    vecs[8]  = '{1'b0, 8'd1, 64'h5000,      1'b0, 64'h100_0000_5000,  1'b0, 1'b0, 3};
    vecs[9]  = '{1'b0, 8'd1, 64'h2000,      1'b0, 64'h100_0000_2000,  1'b1, 1'b0, 2};
    vecs[10] = '{1'b0, 8'd1, 64'h1000,      1'b0, 64'h100_0000_1000,  1'b0, 1'b0, 3};
    vecs[11] = '{1'b0, 8'd1, 64'h5234,      1'b0, 64'h100_0000_5234,  1'b1, 1'b0, 2};
    vecs[12] = '{1'b1, 8'd3, 64'h1000,      1'b0, 64'h1_0000_1000,    1'b0, 1'b0, 3};
    vecs[13] = '{1'b0, 8'd4, 64'h1000,      1'b0, 64'h400_0000_1000,  1'b0, 1'b0, 3};

    repeat (3) step();
    chk("rst.req_ready", 64'(u_if.req_ready_o), 64'd0);
    chk("rst.resp_valid", 64'(u_if.resp_valid_o), 64'd0);
    chk("rst.ept_valid", 64'(u_if.ept_valid_o), 64'd0);
    chk("rst.resp_hpa", u_if.resp_hpa_o, 64'h0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 14; i++) begin
      if (vecs[i].flush_all) flush_pulse(1'b1, 8'h0);
      do_req(vecs[i].vmid, vecs[i].gpa, vecs[i].fault, vecs[i].hpa, vecs[i].hit,
             vecs[i].flt, vecs[i].lat, 1'b0, $sformatf("vec%0d", i));
    end

    // Flush by vmid: vmid 3 entry dropped, vmid 4 entry kept.
    flush_pulse(1'b0, 8'd3);
    do_req(8'd4, 64'h1000, 1'b0, 64'h400_0000_1000, 1'b1, 1'b0, 2, 1'b0, "fv.v4_hit");
    do_req(8'd3, 64'h1000, 1'b0, 64'h1_0000_1000,   1'b0, 1'b0, 3, 1'b0, "fv.v3_miss");

    // Flush during WALK suppresses the fill but not the response.
    do_req(8'd3, 64'h7000, 1'b0, 64'h1_0000_7000, 1'b0, 1'b0, 3, 1'b1, "fw.resp");
    do_req(8'd3, 64'h7000, 1'b0, 64'h1_0000_7000, 1'b0, 1'b0, 3, 1'b0, "fw.remiss");

    // Backpressure on a hit.
    begin
      int cyc;
      u_if.req_vmid_i  = 8'd4;
      u_if.req_gpa_i   = 64'h1ABC;
      u_if.req_valid_i = 1'b1;
      u_if.resp_ready_i = 1'b0;
      step();
      u_if.req_valid_i = 1'b0;
      cyc = 1;
      while (!u_if.resp_valid_o && cyc < 20) begin
        step();
        cyc++;
      end
      chk("bp.lat", 64'(cyc), 64'd2);
      for (int k = 0; k < 5; k++) begin
        chk($sformatf("bp.valid%0d", k), 64'(u_if.resp_valid_o), 64'd1);
        chk($sformatf("bp.hpa%0d", k), u_if.resp_hpa_o, 64'h400_0000_1ABC);
        chk($sformatf("bp.hit%0d", k), 64'(u_if.resp_hit_o), 64'd1);
        chk($sformatf("bp.req_ready%0d", k), 64'(u_if.req_ready_o), 64'd0);
        step();
      end
      u_if.resp_ready_i = 1'b1;
      chk("bp.valid_release", 64'(u_if.resp_valid_o), 64'd1);
      step();
      chk("bp.valid_after", 64'(u_if.resp_valid_o), 64'd0);
      chk("bp.idle_ready", 64'(u_if.req_ready_o), 64'd1);
    end

    // Reset during WALK.
    begin
      int cyc;
      u_if.req_vmid_i  = 8'd4;
      u_if.req_gpa_i   = 64'h9000;
      u_if.req_valid_i = 1'b1;
      step();
      u_if.req_valid_i = 1'b0;
      cyc = 1;
      while (!u_if.ept_valid_o && cyc < 20) begin
        step();
        cyc++;
      end
      chk("rw.walk_cycle", 64'(cyc), 64'd2);
      rst = 1'b1;
      step();
      chk("rw.resp_valid", 64'(u_if.resp_valid_o), 64'd0);
      chk("rw.ept_valid", 64'(u_if.ept_valid_o), 64'd0);
      chk("rw.ept_gpa", u_if.ept_gpa_o, 64'h0);
      chk("rw.resp_hpa", u_if.resp_hpa_o, 64'h0);
      chk("rw.req_ready", 64'(u_if.req_ready_o), 64'd0);
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
        step();
        chk($sformatf("rw.no_resp%0d", k), 64'(u_if.resp_valid_o), 64'd0);
      end
      do_req(8'd4, 64'h1000, 1'b0, 64'h400_0000_1000, 1'b0, 1'b0, 3, 1'b0, "rw.cold");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ept_tlb.md
Name: ept_tlb

Overview:
- Small fully-associative GPA->HPA translation cache that sits directly upstream of the ept translate stage.
- Accepts guest translation requests on a valid/ready handshake and answers hits from local entries.
- On a miss it issues a single-cycle lookup to ept, captures the result, and fills an entry on success.
- Returns one response per request on a valid/ready handshake. One request in flight at a time.

Parameters:
ENTRIES, 4, number of cache entries (power of two, >=2)
PAGE_SHIFT, 12, page-offset width; tag/data granularity

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
req_valid_i  input  1  request valid
req_ready_o  output  1  request ready
req_vmid_i  input  8  requesting VM id
req_gpa_i  input  64  guest physical address
resp_valid_o  output  1  response valid
resp_ready_i  input  1  response ready
resp_hpa_o  output  64  host physical address
resp_fault_o  output  1  translation fault
resp_hit_o  output  1  response served from cache
flush_i  input  1  invalidate strobe
flush_all_i  input  1  with flush_i: invalidate all entries
flush_vmid_i  input  8  with flush_i and !flush_all_i: invalidate entries of this vmid
ept_valid_o  output  1  lookup strobe to ept (translate_valid_i)
ept_vmid_o  output  8  vmid to ept
ept_gpa_o  output  64  gpa to ept
ept_hpa_i  input  64  hpa from ept (combinational, same cycle)
ept_fault_i  input  1  fault from ept (same cycle)

Behaviour:
- Reset
  - Synchronous, active-high; wins over all other activity, including mid-walk or mid-response.
  - Effects: state IDLE, all entry valid bits 0, replacement pointer 0, request register 0.
  - Outputs: resp_valid_o/resp_fault_o/resp_hit_o/ept_valid_o = 0; resp_hpa_o/ept_vmid_o/ept_gpa_o = 0.
  - req_ready_o = 0 while rst is high.
- Entry contents: valid, vmid[7:0], vpn = gpa[63:PAGE_SHIFT], ppn = hpa[63:PAGE_SHIFT].
- Translations preserve page offset (system rule: EPT keys have zero low PAGE_SHIFT bits). Hit hpa = {ppn, gpa[PAGE_SHIFT-1:0]}.
- FSM states: IDLE, CHECK, WALK, RESP.
  - IDLE: req_ready_o=1. On req_valid_i, latch vmid/gpa and go to CHECK.
  - CHECK: compare the request against all valid entries, matching on both vmid and vpn.
    - Hit (lowest index on multiple matches): load resp_hpa_o, resp_hit_o=1, resp_fault_o=0, go to RESP.
    - Miss: go to WALK.
  - WALK (exactly 1 cycle): ept_valid_o=1; ept_vmid_o/ept_gpa_o = request register (0 in all other states).
    - Capture ept_hpa_i/ept_fault_i at the clock edge; resp_hit_o=0; go to RESP.
    - No fault: resp_hpa_o=ept_hpa_i and fill an entry.
    - Fault: resp_hpa_o=0, resp_fault_o=1, no fill. Faults are never cached.
  - RESP: resp_valid_o=1 with resp_hpa_o/resp_fault_o/resp_hit_o held stable until resp_ready_i is sampled high, then go to IDLE.
    - resp_valid_o drops the cycle after the handshake.
    - req_ready_o=0 in CHECK, WALK, RESP; no request is accepted in the handshake cycle.
- Latency (request handshake at cycle 0, resp_ready_i held high): hit response valid at cycle 2; miss at cycle 3. Back-to-back throughput: one request per 3 cycles (hit) or 4 cycles (miss).
- Replacement on fill:
  - If any entry is invalid, use the lowest-index invalid entry; the pointer is unchanged.
  - Otherwise evict the entry at the pointer and increment the pointer modulo ENTRIES.
- Flush
  - Acts in any state, in the same cycle flush_i is high.
  - flush_all_i clears all valid bits; otherwise clears entries whose vmid == flush_vmid_i.
  - A response already in RESP is unaffected.
  - Flush coincident with a CHECK hit: the hit result is still returned.
  - Flush coincident with a WALK fill whose vmid is covered by the flush: the fill is suppressed (flush wins); the response still carries ept_hpa_i.
- Outputs driven from registers except req_ready_o and the ept_* signals, which decode state.

Test Plan:
- Cold miss then hit, bench ept key for vmid 3 = 0x0000_0001_0000_0000:
  - Request vmid 3, gpa 0x1234_5678 -> ept_valid_o high exactly at cycle 2 with ept_gpa_o=0x1234_5678; resp at cycle 3: hpa 0x1_1234_5678, hit=0, fault=0.
  - Then gpa 0x1234_5ABC -> resp at cycle 2: hpa 0x1_1234_5ABC, hit=1, no ept_valid_o.
- Fault: bench drives ept_fault_i=1 for vmid 9, gpa 0x8000 -> resp fault=1, hpa=0, hit=0. Repeating the request produces another WALK (not cached).
- Eviction with ENTRIES=4: fill pages 0x1000, 0x2000, 0x3000, 0x4000, 0x5000 (vmid 1) -> 0x5000 replaces entry 0. Request 0x1000 misses; request 0x2000 hits.
- Flush by vmid:
  - Cache vmid 3 page 0x1000 and vmid 4 page 0x1000; pulse flush_i with flush_vmid_i=3 -> vmid 3 misses, vmid 4 hits.
  - Flush coincident with the WALK cycle for vmid 3 -> response correct, subsequent request misses.
- Backpressure: hold resp_ready_i low 5 cycles in RESP -> resp_valid_o and data stable, req_ready_o=0 throughout; single transfer on release; IDLE next cycle.
- Reset mid-walk: assert rst during WALK -> next cycle all outputs 0, no response issued. Previously cached page then misses (valid bits cleared).
